// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COARSE,
        FINE,
        DONE
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational fixed-distance shifter: moves data by SH bits, vacated bits take fill.
module shift_step_unit
    import shift_seq_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned SH = 1
) (
    input  logic [W-1:0] data,
    input  logic         dir,
    input  logic         fill,
    output logic [W-1:0] result
);

    always_comb begin
        if (dir == DIR_LEFT) begin
            result = {data[W-SH-1:0], {SH{fill}}};
        end else begin
            result = {{SH{fill}}, data[W-1:SH]};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable shifter: coarse STEP-bit steps, then 1-bit steps, until the amount is used.
// Optional arithmetic right shift via macro SHIFT_SEQ_ARITH_EN (adds the up_arith port).
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned STEP = 3,
    parameter int unsigned AW   = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [W-1:0]  up_data,
    input  logic [AW-1:0] up_amount,
    input  logic          up_dir,
`ifdef SHIFT_SEQ_ARITH_EN
    input  logic          up_arith,
`endif
    output logic          down_valid,
    input  logic          down_ready,
    output logic [W-1:0]  down_data,
    output logic          busy
);

    state_t        state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [AW-1:0] remaining_q, remaining_d;
    logic          dir_q, dir_d;
    logic          fill_q, fill_d;
    logic          accept_fill;
    logic [W-1:0]  coarse_out, fine_out;

`ifdef SHIFT_SEQ_ARITH_EN
    assign accept_fill = up_arith & (up_dir == DIR_RIGHT) & up_data[W-1];
`else
    assign accept_fill = 1'b0;
`endif

    function automatic state_t step_state(input logic [AW-1:0] rem);
        if (rem >= AW'(STEP)) begin
            return COARSE;
        end else if (rem != '0) begin
            return FINE;
        end
        return DONE;
    endfunction

    shift_step_unit #(
        .W  (W),
        .SH (STEP)
    ) u_coarse (
        .data   (data_q),
        .dir    (dir_q),
        .fill   (fill_q),
        .result (coarse_out)
    );

    shift_step_unit #(
        .W  (W),
        .SH (1)
    ) u_fine (
        .data   (data_q),
        .dir    (dir_q),
        .fill   (fill_q),
        .result (fine_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            remaining_q <= '0;
            dir_q       <= DIR_LEFT;
            fill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            fill_q      <= fill_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        fill_d      = fill_q;
        unique case (state_q)
            IDLE: begin
                if (up_valid) begin
                    data_d      = up_data;
                    dir_d       = up_dir;
                    fill_d      = accept_fill;
                    remaining_d = up_amount;
                    // Everything shifts out: result is pure fill, no stepping needed.
                    if (up_amount >= AW'(W)) begin
                        data_d  = {W{accept_fill}};
                        state_d = DONE;
                    end else begin
                        state_d = step_state(up_amount);
                    end
                end
            end
            COARSE: begin
                data_d      = coarse_out;
                remaining_d = remaining_q - AW'(STEP);
                state_d     = step_state(remaining_d);
            end
            FINE: begin
                data_d      = fine_out;
                remaining_d = remaining_q - AW'(1);
                state_d     = (remaining_d == '0) ? DONE : FINE;
            end
            DONE: begin
                if (down_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        up_ready   = rst_n && (state_q == IDLE);
        down_valid = (state_q == DONE);
        down_data  = data_q;
        busy       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer (W=8, STEP=3) against a behavioural shift model.
module tb_shift_sequencer;

    localparam int unsigned W    = 8;
    localparam int unsigned STEP = 3;
    localparam int unsigned AW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          up_valid;
    logic          up_ready;
    logic [W-1:0]  up_data;
    logic [AW-1:0] up_amount;
    logic          up_dir;
    logic          up_arith;
    logic          down_valid;
    logic          down_ready;
    logic [W-1:0]  down_data;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    shift_sequencer #(
        .W    (W),
        .STEP (STEP),
        .AW   (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_amount  (up_amount),
        .up_dir     (up_dir),
`ifdef SHIFT_SEQ_ARITH_EN
        .up_arith   (up_arith),
`endif
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference: the whole shift at once, plus the cycle count from the step rule.
    function automatic logic [W-1:0] model_res(input logic [W-1:0] d, input int a,
                                                input logic dr, input logic ar);
        logic fill;
        fill = dr && ar && d[W-1];
        if (a >= int'(W)) return {W{fill}};
        if (!dr) return d << a;
        if (ar) return W'($signed(d) >>> a);
        return d >> a;
    endfunction

    function automatic int model_lat(input int a);
        if (a >= int'(W)) return 1;
        return 1 + a / int'(STEP) + a % int'(STEP);
    endfunction

    function automatic logic rand_arith();
`ifdef SHIFT_SEQ_ARITH_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    // Present a request at a negedge, wait for acceptance, return at the negedge of c0+1.
    task automatic send(input logic [W-1:0] d, input int a, input logic dr, input logic ar);
        int guard = 0;
        up_valid  = 1'b1;
        up_data   = d;
        up_amount = AW'(a);
        up_dir    = dr;
        up_arith  = ar;
        while (!up_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        up_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic ok);
        lat = 1;
        while (!down_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ok = down_valid;
    endtask

    task automatic consume();
        down_ready = 1'b1;
        @(negedge clk);
        down_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, down_valid, up_ready, down_data} !== 11'b0)
            $display("FAIL reset_outputs: busy=%b valid=%b ready=%b data=%h, want all 0",
                     busy, down_valid, up_ready, down_data);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (up_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", up_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [W-1:0] td [6] = '{8'hB5, 8'hFF, 8'h5A, 8'hC3, 8'h90, 8'h80};
        int           ta [6] = '{5, 7, 0, 9, 4, 9};
        logic         tr [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic         tx [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] te [6] = '{8'hA0, 8'h01, 8'h5A, 8'h00, 8'hF9, 8'hFF};
        int           tl [6] = '{4, 4, 1, 1, 3, 1};
        int           nvec;
        int           lat;
        logic         ok;
`ifdef SHIFT_SEQ_ARITH_EN
        nvec = 6;
`else
        nvec = 4;
`endif
        for (int i = 0; i < nvec; i++) begin
            send(td[i], ta[i], tr[i], tx[i]);
            wait_done(lat, ok);
            n_checks++;
            if (!ok || down_data !== te[i])
                $display("FAIL directed_data[%0d]: got %h (valid=%b) want %h",
                         i, down_data, ok, te[i]);
            else n_pass++;
            n_checks++;
            if (lat != tl[i]) $display("FAIL directed_latency[%0d]: got %0d want %0d",
                                       i, lat, tl[i]);
            else n_pass++;
            consume();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        int           a;
        logic         dr, ar;
        int           lat;
        logic         ok;
        for (int i = 0; i < 30; i++) begin
            d  = W'($urandom);
            a  = $urandom_range(0, 15);
            dr = 1'($urandom_range(0, 1));
            ar = rand_arith();
            send(d, a, dr, ar);
            wait_done(lat, ok);
            n_checks++;
            if (!ok || down_data !== model_res(d, a, dr, ar) || lat != model_lat(a))
                $display("FAIL random[%0d] d=%h a=%0d dir=%b ar=%b: got %h lat %0d, want %h lat %0d",
                         i, d, a, dr, ar, down_data, lat, model_res(d, a, dr, ar), model_lat(a));
            else n_pass++;
            consume();
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        logic ok;
        send(8'hB5, 5, 1'b0, 1'b0);
        wait_done(lat, ok);
        // A new request waits while the result is held.
        up_valid  = 1'b1;
        up_data   = 8'h3C;
        up_amount = AW'(4);
        up_dir    = 1'b1;
        up_arith  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (down_valid !== 1'b1 || down_data !== 8'hA0 || up_ready !== 1'b0)
                $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b, want 1/a0/0",
                         i, down_valid, down_data, up_ready);
            else n_pass++;
            @(negedge clk);
        end
        down_ready = 1'b1;
        @(negedge clk);
        down_ready = 1'b0;
        n_checks++;
        if (up_ready !== 1'b1 || busy !== 1'b0 || down_valid !== 1'b0)
            $display("FAIL bp_bubble: ready=%b busy=%b valid=%b, want 1/0/0",
                     up_ready, busy, down_valid);
        else n_pass++;
        @(negedge clk);
        up_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL bp_accept_next: busy=%b want 1", busy);
        else n_pass++;
        wait_done(lat, ok);
        n_checks++;
        if (!ok || down_data !== 8'h03 || lat != 3)
            $display("FAIL bp_next_result: got %h lat %0d want 03 lat 3", down_data, lat);
        else n_pass++;
        consume();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d, nd;
        int           a, na;
        logic         dr, ar, ndr, nar;
        int           lat;
        logic         ok;
        d  = W'($urandom);
        a  = $urandom_range(0, 15);
        dr = 1'($urandom_range(0, 1));
        ar = rand_arith();
        send(d, a, dr, ar);
        for (int i = 0; i < 8; i++) begin
            wait_done(lat, ok);
            n_checks++;
            if (!ok || down_data !== model_res(d, a, dr, ar) || lat != model_lat(a))
                $display("FAIL b2b[%0d] d=%h a=%0d dir=%b ar=%b: got %h lat %0d, want %h lat %0d",
                         i, d, a, dr, ar, down_data, lat, model_res(d, a, dr, ar), model_lat(a));
            else n_pass++;
            if (i == 7) begin
                consume();
            end else begin
                nd  = W'($urandom);
                na  = $urandom_range(0, 15);
                ndr = 1'($urandom_range(0, 1));
                nar = rand_arith();
                up_valid   = 1'b1;
                up_data    = nd;
                up_amount  = AW'(na);
                up_dir     = ndr;
                up_arith   = nar;
                down_ready = 1'b1;
                @(negedge clk);
                down_ready = 1'b0;
                n_checks++;
                if (up_ready !== 1'b1) $display("FAIL b2b_idle[%0d]: ready=%b want 1", i, up_ready);
                else n_pass++;
                @(posedge clk);
                @(negedge clk);
                up_valid = 1'b0;
                d  = nd;
                a  = na;
                dr = ndr;
                ar = nar;
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic seen = 1'b0;
        send(8'hA7, 7, 1'b1, 1'b0);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: busy=%b want 1", busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (up_ready !== 1'b0) $display("FAIL rst_mid_ready_low: ready=%b want 0", up_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || down_valid !== 1'b0 || down_data !== 8'h00)
            $display("FAIL rst_mid_clear: busy=%b valid=%b data=%h, want 0/0/00",
                     busy, down_valid, down_data);
        else n_pass++;
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (down_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL rst_mid_no_result: valid seen=%b want 0", seen);
        else n_pass++;
    endtask

    initial begin
        rst_n      = 1'b0;
        up_valid   = 1'b0;
        up_data    = '0;
        up_amount  = '0;
        up_dir     = 1'b0;
        up_arith   = 1'b0;
        down_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_directed();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
